// File: rtl/sprite_layer_pkg.sv
// Shared constants and helpers for the sprite compositor: texel layout and
// index-width arithmetic.
package sprite_pkg;

   localparam int CB_DEF   = 3;
   localparam int TEX_BITS = 3 * CB_DEF;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Select fields need at least one bit even for a single sprite.
   function automatic int sel_w(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

   // Packed texel is {R, G, B} with R in the MSBs.
   function automatic int r_lsb(input int cb);
      return 2 * cb;
   endfunction

   function automatic int g_lsb(input int cb);
      return cb;
   endfunction

   function automatic int b_lsb(input int cb);
      return 0 * cb;
   endfunction

endpackage

// File: rtl/sprite_hit.sv
// Stage-1 overlap test for one sprite: hit flag and texel index within the
// sprite bitmap, with optional horizontal mirroring.
module sprite_hit
   import sprite_pkg::*;
#(
   parameter int SPR_W = 16,
   parameter int SPR_H = 16,
   parameter int XW    = 10,
   parameter int IW    = 8
) (
   input  logic          pix_valid,
   input  logic [XW-1:0] x_vga,
   input  logic [XW-1:0] y_vga,
   input  logic [XW-1:0] pos_x,
   input  logic [XW-1:0] pos_y,
   input  logic          en,
   input  logic          mirror,
   output logic          hit,
   output logic [IW-1:0] idx
);

   localparam int CW = sel_w(SPR_W);
   localparam int RW = sel_w(SPR_H);

   logic [XW:0]   dx;
   logic [XW:0]   dy;
   logic          in_x;
   logic          in_y;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // One extra bit makes the difference signed, so a sprite past the right
   // or bottom edge never wraps around onto low coordinates.
   always_comb begin
      dx   = {1'b0, x_vga} - {1'b0, pos_x};
      dy   = {1'b0, y_vga} - {1'b0, pos_y};
      in_x = !dx[XW] && (dx < (XW+1)'(SPR_W));
      in_y = !dy[XW] && (dy < (XW+1)'(SPR_H));
      hit  = en && pix_valid && in_x && in_y;
      col  = mirror ? (CW'(SPR_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
      row  = dy[RW-1:0];
      idx  = IW'(row) * IW'(SPR_W) + IW'(col);
   end

endmodule

// File: rtl/sprite_layer.sv
// Multi-sprite pixel compositor: frame-synchronous position registers, a
// per-sprite hit stage and a priority/transparency output stage.
module sprite_layer
   import sprite_pkg::*;
#(
   parameter int               NUM_SPR = 4,
   parameter int               SPR_W   = 16,
   parameter int               SPR_H   = 16,
   parameter int               CB      = 3,
   parameter int               XW      = 10,
   parameter logic [3*CB-1:0]  TRANSP  = '0
) (
   input  logic                                CLK,
   input  logic                                reset,
   input  logic                                pix_valid,
   input  logic [XW-1:0]                       X_VGA,
   input  logic [XW-1:0]                       Y_VGA,
   input  logic                                frame_start,
   input  logic                                pos_we,
   input  logic [sel_w(NUM_SPR)-1:0]           pos_sel,
   input  logic [XW-1:0]                       pos_x,
   input  logic [XW-1:0]                       pos_y,
   input  logic                                pos_en,
   input  logic                                pos_mirror,
   input  logic [NUM_SPR*SPR_H*SPR_W*3*CB-1:0] BITMAPS,
   input  logic [3*CB-1:0]                     bg_rgb,
   output logic [3*CB-1:0]                     rgb_out,
   output logic                                valid_out,
   output logic [sel_w(NUM_SPR)-1:0]           hit_id,
   output logic                                hit_valid
);

   localparam int TB   = 3 * CB;
   localparam int SW   = sel_w(NUM_SPR);
   localparam int NPIX = SPR_W * SPR_H;
   localparam int IW   = sel_w(NPIX);

   typedef struct packed {
      logic [XW-1:0] x;
      logic [XW-1:0] y;
      logic          en;
      logic          mirror;
   } pos_t;

   pos_t [NUM_SPR-1:0]          shd_q, shd_d;
   pos_t [NUM_SPR-1:0]          act_q, act_d;

   logic [NUM_SPR-1:0]          hit_w;
   logic [NUM_SPR-1:0][IW-1:0]  idx_w;

   logic [NUM_SPR-1:0]          hit1_q, hit1_d;
   logic [NUM_SPR-1:0][IW-1:0]  idx1_q, idx1_d;
   logic [2:1]                  vld_pipe_q, vld_pipe_d;

   logic [TB-1:0]               rgb_q, rgb_d;
   logic [SW-1:0]               id_q, id_d;
   logic                        hv_q, hv_d;

   logic [NUM_SPR-1:0][TB-1:0]  texel;
   logic                        found;
   logic [SW-1:0]               win;
   logic [TB-1:0]               win_tex;

   // A write in the frame_start cycle lands in both sets at once.
   always_comb begin
      shd_d = shd_q;
      if (pos_we && (32'(pos_sel) < NUM_SPR))
         shd_d[pos_sel] = '{x: pos_x, y: pos_y, en: pos_en, mirror: pos_mirror};
      act_d = frame_start ? shd_d : act_q;
   end

   for (genvar s = 0; s < NUM_SPR; s++) begin : g_spr
      sprite_hit #(
         .SPR_W (SPR_W),
         .SPR_H (SPR_H),
         .XW    (XW),
         .IW    (IW)
      ) u_hit (
         .pix_valid (pix_valid),
         .x_vga     (X_VGA),
         .y_vga     (Y_VGA),
         .pos_x     (act_q[s].x),
         .pos_y     (act_q[s].y),
         .en        (act_q[s].en),
         .mirror    (act_q[s].mirror),
         .hit       (hit_w[s]),
         .idx       (idx_w[s])
      );
   end

   always_comb begin
      hit1_d     = hit_w;
      idx1_d     = idx_w;
      vld_pipe_d = {vld_pipe_q[1], pix_valid};
   end

   // Scan from lowest priority upward so the lowest-index opaque sprite
   // is the last to overwrite the winner.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      win_tex = '0;
      texel   = '0;
      for (int s = NUM_SPR - 1; s >= 0; s--) begin
         texel[s] = BITMAPS[(s * NPIX + int'(idx1_q[s])) * TB +: TB];
         if (hit1_q[s] && (texel[s] != TRANSP)) begin
            found   = 1'b1;
            win     = SW'(s);
            win_tex = texel[s];
         end
      end
      if (!vld_pipe_q[1]) begin
         rgb_d = '0;
         hv_d  = 1'b0;
         id_d  = '0;
      end else if (found) begin
         rgb_d = win_tex;
         hv_d  = 1'b1;
         id_d  = win;
      end else begin
         rgb_d = bg_rgb;
         hv_d  = 1'b0;
         id_d  = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         shd_q      <= '0;
         act_q      <= '0;
         hit1_q     <= '0;
         idx1_q     <= '0;
         vld_pipe_q <= '0;
         rgb_q      <= '0;
         hv_q       <= 1'b0;
         id_q       <= '0;
      end else begin
         shd_q      <= shd_d;
         act_q      <= act_d;
         hit1_q     <= hit1_d;
         idx1_q     <= idx1_d;
         vld_pipe_q <= vld_pipe_d;
         rgb_q      <= rgb_d;
         hv_q       <= hv_d;
         id_q       <= id_d;
      end
   end

   assign rgb_out   = rgb_q;
   assign valid_out = vld_pipe_q[2];
   assign hit_valid = hv_q;
   assign hit_id    = id_q;

endmodule

// File: tb/tb_sprite_layer.sv
// Self-checking bench for sprite_layer: directed vectors, corner sequences
// and a randomized stream against a geometric reference model.
module tb_sprite_layer;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int H  = 16;
   localparam int XW = 10;
   localparam logic [8:0] TRANSP = 9'h000;

   logic              CLK = 1'b0;
   logic              reset;
   logic              pix_valid;
   logic [XW-1:0]     X_VGA, Y_VGA;
   logic              frame_start;
   logic              pos_we;
   logic [1:0]        pos_sel;
   logic [XW-1:0]     pos_x, pos_y;
   logic              pos_en, pos_mirror;
   logic [N*H*W*9-1:0] BITMAPS;
   logic [8:0]        bg_rgb;
   logic [8:0]        rgb_out;
   logic              valid_out;
   logic [1:0]        hit_id;
   logic              hit_valid;

   sprite_layer dut (
      .CLK(CLK), .reset(reset), .pix_valid(pix_valid), .X_VGA(X_VGA), .Y_VGA(Y_VGA),
      .frame_start(frame_start), .pos_we(pos_we), .pos_sel(pos_sel), .pos_x(pos_x),
      .pos_y(pos_y), .pos_en(pos_en), .pos_mirror(pos_mirror), .BITMAPS(BITMAPS),
      .bg_rgb(bg_rgb), .rgb_out(rgb_out), .valid_out(valid_out), .hit_id(hit_id),
      .hit_valid(hit_valid)
   );

   always #5 CLK = ~CLK;

   typedef struct { int x; int y; bit en; bit mir; } spr_t;
   typedef struct { logic [8:0] rgb; bit vld; bit hv; int id; } out_t;
   typedef struct { int x; int y; bit pv; logic [8:0] rgb; bit hv; int id; } vec_t;

   logic [8:0] bmp [N][H][W];
   spr_t shd [N];
   spr_t act [N];
   out_t e1, e2;
   int   n_tests = 0;
   int   n_fail  = 0;

   always_comb begin
      BITMAPS = '0;
      for (int s = 0; s < N; s++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               BITMAPS[((s*H + r)*W + c)*9 +: 9] = bmp[s][r][c];
   end

   // Geometry from the rules: rectangle containment, mirrored column,
   // first opaque sprite in priority order.
   function automatic out_t model(int x, int y, bit pv);
      out_t o;
      o = '{rgb: 9'h000, vld: pv, hv: 1'b0, id: 0};
      if (!pv) return o;
      o.rgb = bg_rgb;
      for (int s = 0; s < N; s++) begin
         if (act[s].en && x >= act[s].x && x < act[s].x + W &&
             y >= act[s].y && y < act[s].y + H) begin
            int c;
            c = x - act[s].x;
            if (act[s].mir) c = W - 1 - c;
            if (bmp[s][y - act[s].y][c] != TRANSP) begin
               o.rgb = bmp[s][y - act[s].y][c];
               o.hv  = 1'b1;
               o.id  = s;
               return o;
            end
         end
      end
      return o;
   endfunction

   task automatic cmp(string nm, out_t e);
      n_tests++;
      if (rgb_out !== e.rgb || valid_out !== e.vld || hit_valid !== e.hv || int'(hit_id) != e.id) begin
         n_fail++;
         $display("FAIL %s: got rgb=%h vld=%b hv=%b id=%0d, want rgb=%h vld=%b hv=%b id=%0d",
                  nm, rgb_out, valid_out, hit_valid, hit_id, e.rgb, e.vld, e.hv, e.id);
      end
   endtask

   // One clock: predict, advance model registers, then check the output of
   // the pixel driven two ticks earlier.
   task automatic tick();
      out_t cur;
      cur = model(int'(X_VGA), int'(Y_VGA), pix_valid);
      if (reset) begin
         for (int s = 0; s < N; s++) begin
            shd[s] = '{0, 0, 1'b0, 1'b0};
            act[s] = '{0, 0, 1'b0, 1'b0};
         end
      end else begin
         if (pos_we) shd[pos_sel] = '{int'(pos_x), int'(pos_y), pos_en, pos_mirror};
         if (frame_start) act = shd;
      end
      @(posedge CLK);
      @(negedge CLK);
      if (reset) begin
         e1 = '{9'h000, 1'b0, 1'b0, 0};
         e2 = e1;
      end else begin
         e2 = e1;
         e1 = cur;
      end
      cmp("stream", e2);
      pos_we      = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle();
      pix_valid = 1'b0;
      tick();
   endtask

   task automatic wr(int s, int x, int y, bit en, bit mir, bit fs);
      pos_we = 1'b1; pos_sel = 2'(s); pos_x = XW'(x); pos_y = XW'(y);
      pos_en = en; pos_mirror = mir; frame_start = fs;
      idle();
   endtask

   task automatic fstart();
      frame_start = 1'b1;
      idle();
   endtask

   task automatic pix_chk(string nm, int x, int y, logic [8:0] rgb, bit hv, int id);
      pix_valid = 1'b1; X_VGA = XW'(x); Y_VGA = XW'(y);
      tick();
      idle();
      cmp(nm, '{rgb, 1'b1, hv, id});
   endtask

   task automatic fill(int s, logic [8:0] v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            bmp[s][r][c] = v;
   endtask

   vec_t vecs [8];

   initial begin
      e1 = '{9'h000, 1'b0, 1'b0, 0};
      e2 = e1;
      for (int s = 0; s < N; s++) begin
         shd[s] = '{0, 0, 1'b0, 1'b0};
         act[s] = shd[s];
         fill(s, 9'h000);
      end
      reset = 1'b1; pix_valid = 1'b0; X_VGA = '0; Y_VGA = '0; frame_start = 1'b0;
      pos_we = 1'b0; pos_sel = '0; pos_x = '0; pos_y = '0; pos_en = 1'b0; pos_mirror = 1'b0;
      bg_rgb = 9'h0A5;
      tick();
      tick();
      cmp("reset_state", '{9'h000, 1'b0, 1'b0, 0});
      reset = 1'b0;
      idle();

      // Defaults: sprite 0 solid white at (100,50)
      fill(0, 9'h1FF);
      wr(0, 100, 50, 1'b1, 1'b0, 1'b0);
      fstart();
      vecs[0] = '{100, 50, 1'b1, 9'h1FF, 1'b1, 0};
      vecs[1] = '{116, 50, 1'b1, 9'h0A5, 1'b0, 0};
      vecs[2] = '{115, 65, 1'b1, 9'h1FF, 1'b1, 0};
      vecs[3] = '{99,  50, 1'b1, 9'h0A5, 1'b0, 0};
      vecs[4] = '{100, 66, 1'b1, 9'h0A5, 1'b0, 0};
      vecs[5] = '{100, 49, 1'b1, 9'h0A5, 1'b0, 0};
      vecs[6] = '{107, 58, 1'b1, 9'h1FF, 1'b1, 0};
      vecs[7] = '{100, 50, 1'b0, 9'h000, 1'b0, 0};
      for (int i = 0; i < 8; i++) begin
         pix_valid = vecs[i].pv; X_VGA = XW'(vecs[i].x); Y_VGA = XW'(vecs[i].y);
         tick();
         idle();
         cmp($sformatf("vec%0d", i), '{vecs[i].rgb, vecs[i].pv, vecs[i].hv, vecs[i].id});
      end

      // Priority at (200,200)
      fill(1, 9'h038);
      wr(0, 200, 200, 1'b1, 1'b0, 1'b0);
      wr(1, 195, 195, 1'b1, 1'b0, 1'b1);
      pix_chk("prio_s0", 200, 200, 9'h1FF, 1'b1, 0);
      bmp[0][0][0] = TRANSP;
      pix_chk("prio_s1", 200, 200, 9'h038, 1'b1, 1);
      bmp[1][5][5] = TRANSP;
      pix_chk("prio_bg", 200, 200, 9'h0A5, 1'b0, 0);

      // Mirror: column 0 red, rest blue
      fill(2, 9'h007);
      for (int r = 0; r < H; r++) bmp[2][r][0] = 9'h1C0;
      wr(2, 10, 300, 1'b1, 1'b1, 1'b1);
      pix_chk("mirror_x25", 25, 300, 9'h1C0, 1'b1, 2);
      pix_chk("mirror_x10", 10, 300, 9'h007, 1'b1, 2);

      // Frame sync
      fill(0, 9'h1FF);
      wr(0, 400, 100, 1'b1, 1'b0, 1'b0);
      pix_chk("sync_old", 200, 200, 9'h1FF, 1'b1, 0);
      pix_chk("sync_notyet", 400, 100, 9'h0A5, 1'b0, 0);
      fstart();
      pix_chk("sync_new", 400, 100, 9'h1FF, 1'b1, 0);
      wr(0, 600, 100, 1'b1, 1'b0, 1'b1);
      pix_chk("sync_coinc", 600, 100, 9'h1FF, 1'b1, 0);

      // Clipping at the right edge
      fill(3, 9'h038);
      wr(3, 1020, 400, 1'b1, 1'b0, 1'b1);
      for (int x = 1020; x < 1024; x++)
         pix_chk($sformatf("clip_%0d", x), x, 400, 9'h038, 1'b1, 3);
      pix_chk("clip_wrap", 0, 401, 9'h0A5, 1'b0, 0);

      // Reset mid-stream
      pix_valid = 1'b1; X_VGA = 10'd1021; Y_VGA = 10'd400;
      tick();
      tick();
      reset = 1'b1;
      tick();
      cmp("rst_mid", '{9'h000, 1'b0, 1'b0, 0});
      reset = 1'b0;
      idle();
      fstart();
      pix_chk("rst_s3_gone", 1021, 400, 9'h0A5, 1'b0, 0);
      pix_chk("rst_s0_gone", 600, 100, 9'h0A5, 1'b0, 0);

      // Randomized stream against the model
      for (int s = 0; s < N; s++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               bmp[s][r][c] = ($urandom_range(0, 3) == 0) ? TRANSP : 9'($urandom_range(1, 511));
      for (int s = 0; s < N; s++)
         wr(s, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      fstart();
      for (int i = 0; i < 3000; i++) begin
         int s;
         s = $urandom_range(0, N - 1);
         pix_valid = ($urandom_range(0, 7) != 0);
         X_VGA = XW'(act[s].x + $urandom_range(0, W + 3) - 2);
         Y_VGA = XW'(act[s].y + $urandom_range(0, H + 3) - 2);
         if ($urandom_range(0, 9) == 0) begin
            pos_we = 1'b1; pos_sel = 2'($urandom_range(0, N - 1));
            pos_x = XW'($urandom_range(0, 1023)); pos_y = XW'($urandom_range(0, 1023));
            pos_en = ($urandom_range(0, 3) != 0); pos_mirror = 1'($urandom_range(0, 1));
         end
         frame_start = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 499) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
      end
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
